button_pulse_capture: RTL and testbench

//   Conditions the two push-buttons (submit, status) that feed the switch input port.
//   Per button: synchronise, debounce, detect the rising edge, and hold a sticky pulse flag.
//   The flags drive submit_posedge / status_posedge on the switch block.

---
 rtl/button_pulse_capture_if.sv | 21 ++
 rtl/button_pulse_capture.sv | 118 +++++++++++
 tb/tb_button_pulse_capture.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/button_pulse_capture_if.sv
// Push-button conditioning bus: raw pins and read-acknowledges in, debounced levels and sticky edge flags out.
interface button_pulse_capture_if;
    logic btn_submit_raw;
    logic btn_status_raw;
    logic clr_submit;
    logic clr_status;
    logic submit_posedge;
    logic status_posedge;
    logic submit_level;
    logic status_level;

    modport master (
        output btn_submit_raw, btn_status_raw, clr_submit, clr_status,
        input  submit_posedge, status_posedge, submit_level, status_level
    );

    modport slave (
        input  btn_submit_raw, btn_status_raw, clr_submit, clr_status,
        output submit_posedge, status_posedge, submit_level, status_level
    );
endinterface

// File: rtl/button_pulse_capture.sv
// Per-button synchroniser, debounce FSM, rising-edge detector and sticky pulse flag for the
// submit and status buttons; each flag is held until the CPU read of its address clears it.
module button_pulse_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    button_pulse_capture_if.slave bus
);

    localparam int unsigned      N_BTN       = 2;
    localparam logic [0:0]       ST_STABLE   = 1'b0;
    localparam logic [0:0]       ST_COUNTING = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is submit, index 1 is status.
    logic [N_BTN-1:0] raw;
    logic [N_BTN-1:0] clr;
    logic [N_BTN-1:0] flag_vec;
    logic [N_BTN-1:0] level_vec;

    assign raw = {bus.btn_status_raw, bus.btn_submit_raw};
    assign clr = {bus.clr_status, bus.clr_submit};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             sync1;
        logic             sync2;
        logic [0:0]       state;
        logic [0:0]       state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level;
        logic             level_nxt;
        logic             level_d;
        logic             rise;
        logic             flag;

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
            end
        end

        // Debounce state, counter and accepted level.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state <= ST_STABLE;
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                level <= level_nxt;
            end
        end

        // Level is accepted only after sync has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            level_nxt = level;
            case (state)
                ST_STABLE: begin
                    if (sync2 != level) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_COUNTING;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                ST_COUNTING: begin
                    if (sync2 == level) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_STABLE;
                    end else if (cnt >= CNT_LAST) begin
                        level_nxt = sync2;
                        cnt_nxt   = '0;
                        state_nxt = ST_STABLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            endcase
        end

        // Registered rise strobe; a press coinciding with an acknowledge keeps the flag set.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                level_d <= 1'b0;
                rise    <= 1'b0;
                flag    <= 1'b0;
            end else begin
                level_d <= level;
                rise    <= level & ~level_d;
                if (rise) begin
                    flag <= 1'b1;
                end else if (clr[i]) begin
                    flag <= 1'b0;
                end
            end
        end

        assign flag_vec[i]  = flag;
        assign level_vec[i] = level;
    end

    assign bus.submit_posedge = flag_vec[0];
    assign bus.status_posedge = flag_vec[1];
    assign bus.submit_level   = level_vec[0];
    assign bus.status_level   = level_vec[1];

endmodule

// File: tb/tb_button_pulse_capture.sv
// Directed bench for button_pulse_capture with a 4-cycle debounce window.
module tb_button_pulse_capture;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    button_pulse_capture_if bus ();

    button_pulse_capture #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    int   lvl_changes;
    int   flag_rises;
    int   seen;
    logic prev_lvl;
    logic prev_flag;

    initial begin
        reset              = 1'b1;
        bus.btn_submit_raw = 1'b0;
        bus.btn_status_raw = 1'b0;
        bus.clr_submit     = 1'b0;
        bus.clr_status     = 1'b0;
        step(2);
        check("rst_submit_flag",  32'(bus.submit_posedge), 0);
        check("rst_status_flag",  32'(bus.status_posedge), 0);
        check("rst_submit_level", 32'(bus.submit_level),   0);
        check("rst_status_level", 32'(bus.status_level),   0);
        reset = 1'b0;
        step(1);

        // Clean press: level at edge 6, flag at edge 8, cleared by acknowledge.
        bus.btn_submit_raw = 1'b1;
        step(5);
        check("clean_level_e5", 32'(bus.submit_level), 0);
        step(1);
        check("clean_level_e6", 32'(bus.submit_level), 1);
        step(1);
        check("clean_flag_e7", 32'(bus.submit_posedge), 0);
        step(1);
        check("clean_flag_e8", 32'(bus.submit_posedge), 1);
        check("clean_status_untouched", 32'(bus.status_posedge), 0);
        step(3);
        check("clean_flag_hold", 32'(bus.submit_posedge), 1);
        bus.clr_submit = 1'b1;
        step(1);
        bus.clr_submit = 1'b0;
        check("clean_flag_cleared", 32'(bus.submit_posedge), 0);
        bus.clr_submit = 1'b1;
        step(1);
        bus.clr_submit = 1'b0;
        check("clr_when_zero", 32'(bus.submit_posedge), 0);
        check("clr_keeps_level", 32'(bus.submit_level), 1);

        // Release produces no flag.
        bus.btn_submit_raw = 1'b0;
        step(10);
        check("release_level", 32'(bus.submit_level), 0);
        check("release_no_flag", 32'(bus.submit_posedge), 0);

        // Glitch of 3 cycles is rejected.
        bus.btn_submit_raw = 1'b1;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) bus.btn_submit_raw = 1'b0;
            step(1);
            if (bus.submit_level || bus.submit_posedge) seen++;
        end
        check("glitch_rejected", 32'(seen), 0);

        // Bounce: toggles every 2 cycles for 12 cycles, then held high.
        lvl_changes = 0;
        flag_rises  = 0;
        prev_lvl    = bus.submit_level;
        prev_flag   = bus.submit_posedge;
        for (int c = 0; c < 28; c++) begin
            bus.btn_submit_raw = (c < 12) ? (((c / 2) % 2) == 0) : 1'b1;
            step(1);
            if (bus.submit_level != prev_lvl) lvl_changes++;
            if (bus.submit_posedge && !prev_flag) flag_rises++;
            prev_lvl  = bus.submit_level;
            prev_flag = bus.submit_posedge;
        end
        check("bounce_level_changes", 32'(lvl_changes), 1);
        check("bounce_flag_rises", 32'(flag_rises), 1);
        check("bounce_flag_final", 32'(bus.submit_posedge), 1);

        // Collision: flag already set, new rise coincides with acknowledge.
        bus.btn_submit_raw = 1'b0;
        step(10);
        check("collide_flag_kept", 32'(bus.submit_posedge), 1);
        bus.btn_submit_raw = 1'b1;
        step(7);
        bus.clr_submit = 1'b1;
        step(1);
        bus.clr_submit = 1'b0;
        check("collide_rise_wins", 32'(bus.submit_posedge), 1);
        step(1);
        check("collide_after", 32'(bus.submit_posedge), 1);
        bus.clr_submit = 1'b1;
        step(1);
        bus.clr_submit = 1'b0;
        check("collide_then_clear", 32'(bus.submit_posedge), 0);

        // Independence: both pressed, clearing submit leaves status set.
        bus.btn_submit_raw = 1'b0;
        step(10);
        bus.btn_submit_raw = 1'b1;
        bus.btn_status_raw = 1'b1;
        step(9);
        check("indep_submit_set", 32'(bus.submit_posedge), 1);
        check("indep_status_set", 32'(bus.status_posedge), 1);
        check("indep_status_level", 32'(bus.status_level), 1);
        bus.clr_submit = 1'b1;
        step(1);
        bus.clr_submit = 1'b0;
        check("indep_submit_clr", 32'(bus.submit_posedge), 0);
        check("indep_status_kept", 32'(bus.status_posedge), 1);

        // Reset mid-debounce with both buttons held; both presses restart from zero.
        bus.btn_submit_raw = 1'b0;
        step(10);
        check("pre_rst_submit_level", 32'(bus.submit_level), 0);
        bus.btn_submit_raw = 1'b1;
        step(4);
        reset = 1'b1;
        #1;
        check("async_rst_status_flag",  32'(bus.status_posedge), 0);
        check("async_rst_status_level", 32'(bus.status_level),   0);
        check("async_rst_submit_flag",  32'(bus.submit_posedge), 0);
        check("async_rst_submit_level", 32'(bus.submit_level),   0);
        step(2);
        reset = 1'b0;
        step(7);
        check("rst_restart_submit_e7", 32'(bus.submit_posedge), 0);
        check("rst_restart_status_e7", 32'(bus.status_posedge), 0);
        step(1);
        check("rst_restart_submit_e8", 32'(bus.submit_posedge), 1);
        check("rst_restart_status_e8", 32'(bus.status_posedge), 1);
        bus.clr_status = 1'b1;
        step(1);
        bus.clr_status = 1'b0;
        check("status_clr", 32'(bus.status_posedge), 0);
        check("status_clr_submit_kept", 32'(bus.submit_posedge), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
